// File: rtl/data_bus_pkg.sv
// Shared types and defaults for the N-to-1 data bus arbiter.
package data_bus_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int MAX_CH     = 16;

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
    onehot = '0;
    onehot[idx[3:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/data_bus_rr_pick.sv
// Combinational winner search over the effective request vector.
// DATA_BUS_FIXED_PRIO_EN: lowest index always wins instead of round-robin.
module data_bus_rr_pick #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  eff_req,
  input  logic [SEL_W-1:0] last_grant,
  output logic             any_req,
  output logic [SEL_W-1:0] winner
);

`ifdef DATA_BUS_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_grant;

  always_comb begin
    any_req = |eff_req;
    winner  = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (eff_req[SEL_W'(i)]) winner = SEL_W'(i);
  end
`else
  // Scan from farthest to nearest so the channel right after last_grant wins.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = |eff_req;
    winner  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N_CH;
      if (eff_req[SEL_W'(idx)]) winner = SEL_W'(idx);
    end
  end
`endif

endmodule

// File: rtl/data_bus_arbiter_nto1.sv
// N-channel round-robin bus selector with a registered valid/ready output.
// DATA_BUS_FIXED_PRIO_EN switches the arbiter to fixed lowest-index priority.
module data_bus_arbiter_nto1
  import data_bus_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        reqIn,
  input  logic [N_CH*DATA_W-1:0] dataIn,
  input  logic                   readyIn,
  output logic [N_CH-1:0]        grantOut,
  output logic [DATA_W-1:0]      dataOut,
  output logic [SEL_W-1:0]       selectOut,
  output logic                   validOut
);

  state_t            state, state_nx;
  logic [SEL_W-1:0]  last_grant, winner;
  logic [N_CH-1:0]   eff_req;
  logic              any_req, handshake, load;
  logic [DATA_W-1:0] words [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_words
    assign words[g] = dataIn[g*DATA_W +: DATA_W];
  end

  // A channel granted last edge has not had a chance to retire its word yet.
  assign eff_req   = reqIn & ~grantOut;
  assign handshake = validOut & readyIn;

  data_bus_rr_pick #(.N_CH(N_CH)) u_pick (
    .eff_req    (eff_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_comb begin
    load     = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        load = any_req;
        if (any_req) state_nx = HOLD;
      end
      HOLD: begin
        load = handshake & any_req;
        if (handshake & ~any_req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut    <= '0;
      selectOut  <= '0;
      validOut   <= 1'b0;
      grantOut   <= '0;
      last_grant <= SEL_W'(N_CH - 1);
    end else begin
      grantOut <= '0;
      if (load) begin
        dataOut   <= words[winner];
        selectOut <= winner;
        validOut  <= 1'b1;
        grantOut  <= N_CH'(onehot(32'(winner)));
`ifndef DATA_BUS_FIXED_PRIO_EN
        last_grant <= winner;
`endif
      end else if (handshake) begin
        validOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter_nto1.sv
// Directed bench for data_bus_arbiter_nto1: a 4x8 and a 3x16 instance checked
// every cycle against a transaction-level model plus literal expectations.
module tb_data_bus_arbiter_nto1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  reqA, gA;
  logic [31:0] dinA;
  logic        rdyA, vA;
  logic [7:0]  dA;
  logic [1:0]  sA;

  logic [2:0]  reqB, gB;
  logic [47:0] dinB;
  logic        rdyB, vB;
  logic [15:0] dB;
  logic [1:0]  sB;

  data_bus_arbiter_nto1 dut_a (
    .clk(clk), .reset(reset), .reqIn(reqA), .dataIn(dinA), .readyIn(rdyA),
    .grantOut(gA), .dataOut(dA), .selectOut(sA), .validOut(vA));

  data_bus_arbiter_nto1 #(.N_CH(3), .DATA_W(16)) dut_b (
    .clk(clk), .reset(reset), .reqIn(reqB), .dataIn(dinB), .readyIn(rdyB),
    .grantOut(gB), .dataOut(dB), .selectOut(sB), .validOut(vB));

  typedef struct {
    logic        valid;
    logic [15:0] data;
    int          sel;
    logic [15:0] grant;
    int          last;
  } mdl_t;

  mdl_t mA, mB;
  int   errs = 0, checks = 0;
  bit   run = 0;

  // One bus transfer per edge: a new word is taken when the output slot is
  // empty or being drained, chosen by priority among unmasked requesters.
  function automatic mdl_t step(mdl_t m, int n, int w, logic [15:0] req,
                                logic [255:0] din, logic rdy, logic rst);
    mdl_t r;
    logic [15:0] eff;
    int win;
    r = m;
    if (rst) begin
      r.valid = 0; r.data = 0; r.sel = 0; r.grant = 0; r.last = n - 1;
      return r;
    end
    eff = req & ~m.grant;
    r.grant = 0;
    if (!m.valid || rdy) begin
      win = -1;
`ifdef DATA_BUS_FIXED_PRIO_EN
      for (int i = 0; i < n; i++) if (eff[i] && win < 0) win = i;
`else
      for (int k = 1; k <= n; k++) if (eff[(m.last + k) % n] && win < 0) win = (m.last + k) % n;
`endif
      if (win >= 0) begin
        r.valid = 1;
        r.data  = 16'(din >> (win * w)) & 16'((32'd1 << w) - 1);
        r.sel   = win;
        r.grant = 16'd1 << win;
`ifndef DATA_BUS_FIXED_PRIO_EN
        r.last  = win;
`endif
      end else begin
        r.valid = 0;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    mA <= step(mA, 4, 8,  16'(reqA), 256'(dinA), rdyA, reset);
    mB <= step(mB, 3, 16, 16'(reqB), 256'(dinB), rdyB, reset);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("a_valid", 32'(vA), 32'(mA.valid));
    chk("a_data",  32'(dA), 32'(mA.data));
    chk("a_sel",   32'(sA), 32'(mA.sel));
    chk("a_grant", 32'(gA), 32'(mA.grant));
    chk("b_valid", 32'(vB), 32'(mB.valid));
    chk("b_data",  32'(dB), 32'(mB.data));
    chk("b_sel",   32'(sB), 32'(mB.sel));
    chk("b_grant", 32'(gB), 32'(mB.grant));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  int          exp4 [6];
  int          exp3 [4];
  logic [15:0] wB   [3];

  initial begin
`ifdef DATA_BUS_FIXED_PRIO_EN
    exp4 = '{0, 1, 0, 1, 0, 1};
    exp3 = '{0, 1, 0, 1};
`else
    exp4 = '{0, 1, 2, 3, 0, 1};
    exp3 = '{0, 1, 2, 0};
`endif
    wB = '{16'h1111, 16'h2222, 16'hBEEF};
    reset = 1; reqA = 0; dinA = 0; rdyA = 0; reqB = 0; dinB = 0; rdyB = 0;
    tick(); tick();
    run = 1;
    chk("rst_valid", 32'(vA), 0);
    chk("rst_data",  32'(dA), 0);
    chk("rst_sel",   32'(sA), 0);
    chk("rst_grant", 32'(gA), 0);
    reset = 0;

    // single request, one-cycle latency
    reqA = 4'b0001; dinA = 32'h04030201; rdyA = 1;
    tick();
    chk("t1_valid", 32'(vA), 1);
    chk("t1_data",  32'(dA), 1);
    chk("t1_sel",   32'(sA), 0);
    chk("t1_grant", 32'(gA), 4'b0001);
    reqA = 0;
    tick();
    chk("t1_idle", 32'(vA), 0);

    // four sources, each drops after its grant
    do_reset();
    reqA = 4'hF;
    tick(); chk("t2_d0", 32'(dA), 1); chk("t2_g0", 32'(gA), 4'b0001); reqA = 4'hE;
    tick(); chk("t2_d1", 32'(dA), 2); chk("t2_g1", 32'(gA), 4'b0010); reqA = 4'hC;
    tick(); chk("t2_d2", 32'(dA), 3); chk("t2_g2", 32'(gA), 4'b0100); reqA = 4'h8;
    tick(); chk("t2_d3", 32'(dA), 4); chk("t2_g3", 32'(gA), 4'b1000); reqA = 4'h0;
    tick(); chk("t2_idle", 32'(vA), 0);

    // back-pressure holds the captured word
    reqA = 4'b0100; rdyA = 0;
    tick();
    chk("t3_data", 32'(dA), 3); chk("t3_sel", 32'(sA), 2); chk("t3_grant", 32'(gA), 4'b0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_data", 32'(dA), 3); chk("t3_hold_valid", 32'(vA), 1);
      chk("t3_hold_grant", 32'(gA), 0);
    end
    dinA = 32'h04FF0201;
    tick();
    chk("t3_stable", 32'(dA), 3);
    rdyA = 1; reqA = 0;
    tick();
    chk("t3_accept", 32'(vA), 0); chk("t3_keep", 32'(dA), 3);

    // continuous requests from all four
    do_reset();
    dinA = 32'h04030201; reqA = 4'hF; rdyA = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_sel",  32'(sA), 32'(exp4[i]));
      chk("t4_data", 32'(dA), 32'(exp4[i] + 1));
    end

    // reset mid-hold discards the word and restores the pointer
    reqA = 0;
    do_reset();
    reqA = 4'b0010; rdyA = 0;
    tick();
    chk("t5_data", 32'(dA), 2); chk("t5_grant", 32'(gA), 4'b0010);
    reset = 1;
    tick();
    chk("t5_valid", 32'(vA), 0); chk("t5_zero", 32'(dA), 0);
    chk("t5_gz", 32'(gA), 0);    chk("t5_sz", 32'(sA), 0);
    reset = 0; reqA = 4'b1010; rdyA = 1;
    tick(); chk("t5_first", 32'(sA), 1);
    reqA = 4'b1000;
    tick(); chk("t5_second", 32'(sA), 3);
    reqA = 0;
    tick(); chk("t5_idle", 32'(vA), 0);

    // three channels, 16-bit words
    do_reset();
    dinB = {16'hBEEF, 16'h2222, 16'h1111}; reqB = 3'b111; rdyB = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_sel",  32'(sB), 32'(exp3[i]));
      chk("t6_data", 32'(dB), 32'(wB[exp3[i]]));
    end
    reqB = 0;
    tick(); tick();
    chk("t6_idle", 32'(vB), 0);

    run = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
